rf_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters.
  - A: main pipeline writeback, high priority.
  - B: multi-cycle unit writeback (mult/div or load miss).
- Fixed priority to A, with a starvation guard that forces a B grant after MAX_WAIT lost cycles.
- Drives the register file write port (RegWrite, WriteRegister, WriteData) from registered outputs, one cycle after grant.

---
 rtl/rf_write_arbiter.sv | 106 ++++++++++
 tb/tb_rf_write_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file write port between the main pipeline (A, high priority)
// and a multi-cycle unit (B), with a starvation guard that forces a B grant.
module rf_write_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = 3,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_reg,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_reg,
   input  logic [DATA_W-1:0] b_data,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteRegister,
   output logic [DATA_W-1:0] WriteData,
   output logic [CNT_W-1:0]  a_grants,
   output logic [CNT_W-1:0]  b_grants
);

   typedef enum logic {NORMAL, FORCE_B} state_t;

   localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

   state_t            state_q, state_d;
   logic [3:0]        waitCnt_q, waitCnt_d;
   logic [3:0]        waitInc;
   logic              regWrite_q, regWrite_d;
   logic [ADDR_W-1:0] writeReg_q, writeReg_d;
   logic [DATA_W-1:0] writeData_q, writeData_d;
   logic [CNT_W-1:0]  aGrants_q, aGrants_d;
   logic [CNT_W-1:0]  bGrants_q, bGrants_d;
   logic              grantA, grantB;

   // Ready depends only on state and valids, never on data or register inputs.
   always_comb begin
      a_ready = (state_q == NORMAL);
      b_ready = (state_q == FORCE_B) || !a_valid;
      grantA  = a_valid && a_ready;
      grantB  = b_valid && b_ready;
      waitInc = waitCnt_q + 4'd1;

      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      if (state_q == FORCE_B) begin
         // Leave the forced slot whether or not B is still there to take it.
         state_d   = NORMAL;
         waitCnt_d = 4'd0;
      end else if (b_valid && !b_ready) begin
         waitCnt_d = waitInc;
         if (waitInc == MaxWait) state_d = FORCE_B;
      end else begin
         waitCnt_d = 4'd0;
      end

      regWrite_d  = 1'b0;
      writeReg_d  = writeReg_q;
      writeData_d = writeData_q;
      aGrants_d   = aGrants_q;
      bGrants_d   = bGrants_q;
      if (grantA) begin
         writeReg_d  = a_reg;
         writeData_d = a_data;
         regWrite_d  = (a_reg != '0);
         if (aGrants_q != '1) aGrants_d = aGrants_q + CNT_W'(1);
      end
      if (grantB) begin
         writeReg_d  = b_reg;
         writeData_d = b_data;
         regWrite_d  = (b_reg != '0);
         if (bGrants_q != '1) bGrants_d = bGrants_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= NORMAL;
         waitCnt_q   <= 4'd0;
         regWrite_q  <= 1'b0;
         writeReg_q  <= '0;
         writeData_q <= '0;
         aGrants_q   <= '0;
         bGrants_q   <= '0;
      end else begin
         state_q     <= state_d;
         waitCnt_q   <= waitCnt_d;
         regWrite_q  <= regWrite_d;
         writeReg_q  <= writeReg_d;
         writeData_q <= writeData_d;
         aGrants_q   <= aGrants_d;
         bGrants_q   <= bGrants_d;
      end
   end

   assign RegWrite      = regWrite_q;
   assign WriteRegister = writeReg_q;
   assign WriteData     = writeData_q;
   assign a_grants      = aGrants_q;
   assign b_grants      = bGrants_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_rf_write_arbiter;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int MAX_WAIT = 3;
   localparam int CNT_W    = 4;
   localparam int SAT      = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic              a_valid, b_valid;
   logic              a_ready, b_ready;
   logic [ADDR_W-1:0] a_reg, b_reg;
   logic [DATA_W-1:0] a_data, b_data;
   logic              RegWrite;
   logic [ADDR_W-1:0] WriteRegister;
   logic [DATA_W-1:0] WriteData;
   logic [CNT_W-1:0]  a_grants, b_grants;

   int checks   = 0;
   int failures = 0;

   // Model state: consecutive B losses, whether B owns the next slot, and expected outputs.
   int                mLost;
   bit                mForced;
   bit                mRegWrite;
   logic [ADDR_W-1:0] mWR;
   logic [DATA_W-1:0] mWD;
   int                mA, mB;

   rf_write_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .a_grants(a_grants), .b_grants(b_grants)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      mLost = 0; mForced = 0; mRegWrite = 0; mWR = '0; mWD = '0; mA = 0; mB = 0;
   endtask

   // Advances the model by one clock using the inputs currently applied.
   task automatic model_advance();
      bit ar, br, ga, gb;
      if (rst) begin
         model_reset();
         return;
      end
      ar = !mForced;
      br = mForced || !a_valid;
      ga = a_valid && ar;
      gb = b_valid && br;
      if (mForced) begin
         mForced = 0; mLost = 0;
      end else if (b_valid && !gb) begin
         mLost++;
         if (mLost == MAX_WAIT) mForced = 1;
      end else begin
         mLost = 0;
      end
      mRegWrite = 0;
      if (ga) begin
         mWR = a_reg; mWD = a_data; mRegWrite = (a_reg != 0);
         if (mA < SAT) mA++;
      end
      if (gb) begin
         mWR = b_reg; mWD = b_data; mRegWrite = (b_reg != 0);
         if (mB < SAT) mB++;
      end
   endtask

   task automatic cycle();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit av, input int ar, input logic [31:0] ad,
                                input bit bv, input int br, input logic [31:0] bd);
      a_valid = av; a_reg = ADDR_W'(ar); a_data = ad;
      b_valid = bv; b_reg = ADDR_W'(br); b_data = bd;
   endtask

   task automatic do_reset();
      applyStimulus(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(1, 9, 32'hAAAA, 1, 10, 32'hBBBB);
      cycle();
      rst = 1'b0;
      checks++;
      if ({RegWrite, WriteRegister, WriteData, a_grants, b_grants} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_values: got RegWrite=%0b WR=%0d WD=%0h ag=%0d bg=%0d required all zero",
                  RegWrite, WriteRegister, WriteData, a_grants, b_grants);
      end
   endtask

   task automatic test_a_alone();
      do_reset();
      applyStimulus(1, 5, 32'h1234, 0, 0, 0);
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL a_alone_ready: got %0b required 1", a_ready);
      end
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++;
      if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'h1234 || a_grants !== 4'd1) begin
         failures++;
         $display("[TB] FAIL a_alone_write: got RegWrite=%0b WR=%0d WD=%0h ag=%0d required 1/5/1234/1",
                  RegWrite, WriteRegister, WriteData, a_grants);
      end
      cycle();
      checks++;
      if (RegWrite !== 1'b0 || WriteRegister !== 5'd5) begin
         failures++; $display("[TB] FAIL a_alone_idle: got RegWrite=%0b WR=%0d required 0/5", RegWrite, WriteRegister);
      end
   endtask

   task automatic test_contention();
      logic [4:0] expWr [5];
      int aIdx;
      bit bDone;
      expWr = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd4};
      aIdx = 1; bDone = 0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, aIdx, 32'h100 + aIdx, !bDone, 7, 32'hBEEF);
         #1;
         checks++;
         if (a_ready !== (i != 3) || b_ready !== (i == 3)) begin
            failures++;
            $display("[TB] FAIL contention_ready[%0d]: got a=%0b b=%0b required a=%0b b=%0b",
                     i, a_ready, b_ready, (i != 3), (i == 3));
         end
         cycle();
         checks++;
         if (WriteRegister !== expWr[i] || RegWrite !== 1'b1) begin
            failures++;
            $display("[TB] FAIL contention_write[%0d]: got WR=%0d RegWrite=%0b required WR=%0d RegWrite=1",
                     i, WriteRegister, RegWrite, expWr[i]);
         end
         if (i == 3) bDone = 1; else aIdx++;
      end
      checks++;
      if (b_grants !== 4'd1 || a_grants !== 4'd4 || WriteData !== 32'h104) begin
         failures++;
         $display("[TB] FAIL contention_counts: got bg=%0d ag=%0d WD=%0h required 1/4/104", b_grants, a_grants, WriteData);
      end
   endtask

   task automatic test_withdraw();
      do_reset();
      for (int i = 0; i < MAX_WAIT; i++) begin
         applyStimulus(1, 10 + i, 32'h55, 1, 20, 32'h66);
         cycle();
      end
      applyStimulus(1, 13, 32'h77, 0, 0, 0);
      #1;
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL withdraw_ready: got a=%0b b=%0b required a=0 b=1", a_ready, b_ready);
      end
      cycle();
      checks++;
      if (RegWrite !== 1'b0 || b_grants !== 4'd0) begin
         failures++; $display("[TB] FAIL withdraw_nogrant: got RegWrite=%0b bg=%0d required 0/0", RegWrite, b_grants);
      end
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL withdraw_back_normal: got a_ready=%0b required 1", a_ready);
      end
      cycle();
      checks++;
      if (RegWrite !== 1'b1 || WriteRegister !== 5'd13 || WriteData !== 32'h77) begin
         failures++;
         $display("[TB] FAIL withdraw_a_after: got RegWrite=%0b WR=%0d WD=%0h required 1/13/77",
                  RegWrite, WriteRegister, WriteData);
      end
   endtask

   task automatic test_zero_write();
      do_reset();
      applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 0);
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL zero_ready: got %0b required 1", a_ready);
      end
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++;
      if (RegWrite !== 1'b0 || a_grants !== 4'd1) begin
         failures++; $display("[TB] FAIL zero_suppress: got RegWrite=%0b ag=%0d required 0/1", RegWrite, a_grants);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 3, 32'h33, 1, 4, 32'h44);
         cycle();
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if ({RegWrite, WriteRegister, WriteData, a_grants, b_grants} !== '0) begin
         failures++;
         $display("[TB] FAIL midwait_reset: got RegWrite=%0b WR=%0d WD=%0h ag=%0d bg=%0d required all zero",
                  RegWrite, WriteRegister, WriteData, a_grants, b_grants);
      end
      for (int i = 0; i < MAX_WAIT + 1; i++) begin
         applyStimulus(1, 3, 32'h33, 1, 4, 32'h44);
         #1;
         checks++;
         if (b_ready !== (i == MAX_WAIT)) begin
            failures++;
            $display("[TB] FAIL midwait_force[%0d]: got b_ready=%0b required %0b", i, b_ready, (i == MAX_WAIT));
         end
         cycle();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 1 + (i % 31), 32'(i), 0, 0, 0);
         cycle();
         checks++;
         if (a_grants !== CNT_W'((i + 1 < SAT) ? i + 1 : SAT)) begin
            failures++;
            $display("[TB] FAIL saturation[%0d]: got ag=%0d required %0d", i, a_grants, (i + 1 < SAT) ? i + 1 : SAT);
         end
      end
   endtask

   task automatic test_random();
      bit expAR, expBR;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom(),
                       $urandom_range(0, 2) != 0, $urandom_range(0, 31), $urandom());
         #1;
         expAR = !mForced;
         expBR = mForced || !a_valid;
         if (!rst) begin
            checks++;
            if (a_ready !== expAR || b_ready !== expBR) begin
               failures++;
               $display("[TB] FAIL random_ready[%0d]: got a=%0b b=%0b required a=%0b b=%0b",
                        i, a_ready, b_ready, expAR, expBR);
            end
         end
         cycle();
         checks++;
         if (RegWrite !== mRegWrite || WriteRegister !== mWR || WriteData !== mWD ||
             a_grants !== CNT_W'(mA) || b_grants !== CNT_W'(mB)) begin
            failures++;
            $display("[TB] FAIL random_out[%0d]: got %0b/%0d/%0h/%0d/%0d required %0b/%0d/%0h/%0d/%0d", i,
                     RegWrite, WriteRegister, WriteData, a_grants, b_grants, mRegWrite, mWR, mWD, mA, mB);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      model_reset();
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      test_reset();
      test_a_alone();
      test_contention();
      test_withdraw();
      test_zero_write();
      test_reset_mid_wait();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
